// File: rtl/fetch_mon_pkg.sv
// Shared types for the fetch-port pass/fail monitor: FSM states, status codes
// and the mapping from a terminal status to its FSM state.
package fetch_mon_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4,
    HANG    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ST_NONE     = 3'd0,
    ST_PASS     = 3'd1,
    ST_PASS_REG = 3'd2,
    ST_FAIL     = 3'd3,
    ST_TIMEOUT  = 3'd4,
    ST_HANG     = 3'd5
  } status_t;

  function automatic logic is_pass(status_t s);
    return (s == ST_PASS) || (s == ST_PASS_REG);
  endfunction

  function automatic state_t state_for(status_t s);
    state_t st;
    case (s)
      ST_PASS, ST_PASS_REG: st = PASS;
      ST_FAIL:              st = FAIL;
      ST_TIMEOUT:           st = TIMEOUT;
      ST_HANG:              st = HANG;
      default:              st = RUN;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mon_sat_counter.sv
// Saturating up-counter with synchronous clear and a freeze input that holds
// the current value; freeze takes priority over clear and increment.
module mon_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         freeze,
  output logic [W-1:0] count
);

  // NOTE: rst is synchronous and active-low, so it only appears inside the
  // clocked block and never in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (!freeze) begin
      if (clr)
        count <= '0;
      else if (inc && (count != '1))
        count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_exit_monitor.sv
// Watches the instruction-fetch port and latches a sticky PASS/FAIL/TIMEOUT/HANG
// verdict; all outputs are registered and freeze once a verdict is reached.
module fetch_exit_monitor
  import fetch_mon_pkg::*;
#(
  parameter logic [31:0] PASS_PC        = 32'h8000_0130,
  parameter logic [31:0] FAIL_PC        = 32'h8000_0134,
  parameter logic [31:0] EXPECTED_VALUE = 32'd63,
  parameter int unsigned TIMEOUT_CYCLES = 2000,
  parameter int unsigned HANG_CYCLES    = 256,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_rd_i,
  input  logic             fetch_accept_i,
  input  logic [31:0]      fetch_pc_i,
  input  logic [31:0]      check_value_i,
  output logic             done_o,
  output logic             pass_o,
  output logic [2:0]       status_o,
  output logic             pc_change_o,
  output logic [31:0]      last_pc_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [31:0]      fetch_count_o
);

  // The timeout compare needs headroom below the saturation value, otherwise a
  // saturated counter could never exceed the limit.
  if (64'(TIMEOUT_CYCLES) >= ((64'(1) << CNT_W) - 64'(1))) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be below 2**CNT_W-1");
  end
  if (64'(HANG_CYCLES) >= ((64'(1) << CNT_W) - 64'(1))) begin : g_bad_hang
    $error("HANG_CYCLES must be below 2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] HANG_LIM    = CNT_W'(HANG_CYCLES);

  state_t           state;
  status_t          status;
  status_t          verdict;
  logic [CNT_W-1:0] idle_cnt;
  logic             accepted;
  logic             in_idle;
  logic             in_run;
  logic             terminal;
  logic             pc_changed;

  assign accepted   = fetch_rd_i & fetch_accept_i;
  assign in_idle    = (state == IDLE);
  assign in_run     = (state == RUN);
  assign terminal   = !(in_idle || in_run);
  assign pc_changed = (fetch_pc_i != last_pc_o);
  assign status_o   = status;

  mon_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (in_idle),
    .inc    (in_run),
    .freeze (terminal),
    .count  (cycle_count_o)
  );

  mon_sat_counter #(.W(CNT_W)) u_idle_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (in_idle || (in_run && accepted)),
    .inc    (in_run),
    .freeze (terminal),
    .count  (idle_cnt)
  );

  // PC verdicts outrank the counter-based ones when they coincide.
  always_comb begin
    verdict = ST_NONE;
    if (pc_changed && (fetch_pc_i == PASS_PC))
      verdict = ST_PASS;
    else if (pc_changed && (fetch_pc_i == FAIL_PC))
      verdict = (check_value_i == EXPECTED_VALUE) ? ST_PASS_REG : ST_FAIL;
    else if (cycle_count_o > TIMEOUT_LIM)
      verdict = ST_TIMEOUT;
    else if (idle_cnt == HANG_LIM)
      verdict = ST_HANG;
  end

  // NOTE: every register here uses non-blocking assignment so all of them
  // update from the same pre-edge values, whatever order the branches run in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      status        <= ST_NONE;
      done_o        <= 1'b0;
      pass_o        <= 1'b0;
      pc_change_o   <= 1'b0;
      last_pc_o     <= '0;
      fetch_count_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          pc_change_o <= 1'b0;
          if (accepted) begin
            state         <= RUN;
            fetch_count_o <= fetch_count_o + 32'd1;
          end
        end
        RUN: begin
          if (accepted)
            fetch_count_o <= fetch_count_o + 32'd1;
          pc_change_o <= pc_changed;
          if (pc_changed)
            last_pc_o <= fetch_pc_i;
          if (verdict != ST_NONE) begin
            state  <= state_for(verdict);
            status <= verdict;
            done_o <= 1'b1;
            pass_o <= is_pass(verdict);
          end
        end
        default: begin
          pc_change_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_exit_monitor.md
Name: fetch_exit_monitor

Overview:
Synthesizable pass/fail monitor that sits directly downstream of the core's instruction-fetch request port, in parallel with tcm_mem. It watches the fetch PC and the accept handshake, tracks PC changes, counts cycles, and declares a terminal verdict: PASS, FAIL, TIMEOUT or HANG. Testbenches and FPGA builds use its sticky status outputs instead of ad-hoc PC comparisons.

Parameters:
PASS_PC, 32'h80000130, fetch PC that signals a passing test
FAIL_PC, 32'h80000134, fetch PC that signals a failing test
EXPECTED_VALUE, 32'd63, value check_value_i must hold at FAIL_PC for a register-match pass
TIMEOUT_CYCLES, 2000, RUN-state cycle limit before TIMEOUT
HANG_CYCLES, 256, consecutive RUN cycles with no accepted fetch before HANG
CNT_W, 16, width of the cycle and idle counters

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
fetch_rd_i  input  1  core fetch request (mem_i_rd)
fetch_accept_i  input  1  memory accepted the fetch request (mem_i_accept)
fetch_pc_i  input  32  fetch PC (mem_i_pc)
check_value_i  input  32  probed architectural value, e.g. x12
done_o  output  1  terminal state reached (sticky)
pass_o  output  1  verdict is pass (PC or register match)
status_o  output  3  status code (see package)
pc_change_o  output  1  one-cycle pulse when fetch_pc_i differs from last_pc_o
last_pc_o  output  32  last sampled fetch PC
cycle_count_o  output  CNT_W  RUN-state cycle count, saturating
fetch_count_o  output  32  number of accepted fetches, wrapping

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, all outputs 0, last_pc_o=0, both counters 0. A reset mid-run clears everything on that edge.
- Handshake: a fetch counts only when fetch_rd_i && fetch_accept_i are both high in the same cycle. fetch_count_o increments by 1 per accepted fetch and wraps at 2^32.
- IDLE: waits for the first accepted fetch, then goes to RUN on the next edge. That fetch is counted. cycle_count_o stays 0 in IDLE.
- RUN:
  - cycle_count_o increments every cycle and saturates at all-ones.
  - idle_cnt clears on an accepted fetch and otherwise increments, saturating.
  - PC sampling happens every cycle, independent of the accept handshake. If fetch_pc_i != last_pc_o, then last_pc_o<=fetch_pc_i and pc_change_o=1 for that cycle only (registered, asserted the cycle after the edge).
  - PC matching is evaluated on the new PC at a PC change.
- Transitions out of RUN, in priority order:
  1. New PC == PASS_PC: go to PASS, status=ST_PASS.
  2. New PC == FAIL_PC and check_value_i==EXPECTED_VALUE: go to PASS, status=ST_PASS_REG.
  3. New PC == FAIL_PC otherwise: go to FAIL, status=ST_FAIL.
  4. cycle_count_o > TIMEOUT_CYCLES: go to TIMEOUT, status=ST_TIMEOUT.
  5. idle_cnt == HANG_CYCLES: go to HANG, status=ST_HANG.
  - A PC match on the same cycle as a timeout or hang resolves to the PC verdict.
- Terminal states (PASS, FAIL, TIMEOUT, HANG):
  - done_o=1 and status_o are sticky until reset.
  - pass_o=1 only for ST_PASS and ST_PASS_REG.
  - All counters and last_pc_o freeze; pc_change_o is held at 0.
- Latency: verdict outputs are registered and valid one edge after the triggering sample.
- Width rule: cycle_count_o is compared as unsigned against TIMEOUT_CYCLES zero-extended to CNT_W. TIMEOUT_CYCLES must be < 2^CNT_W-1, enforced by an elaboration-time check.

Decomposition:
- Package fetch_mon_pkg:
  - state enum: IDLE, RUN, PASS, FAIL, TIMEOUT, HANG.
  - status codes: ST_NONE=0, ST_PASS=1, ST_PASS_REG=2, ST_FAIL=3, ST_TIMEOUT=4, ST_HANG=5.
- One sub-module, mon_sat_counter: parameterised width, with clr, inc and freeze inputs and saturation at all-ones. It is instantiated for cycle_count and idle_cnt.

Test Plan:
- Reset and idle: hold rst=0 for 5 cycles, then release with no fetch for 50 cycles -> state IDLE, done_o=0, cycle_count_o=0, status_o=0.
- Pass path: accept fetches at 0x80000000, 0x80000004, ..., then PC 0x80000130 -> pc_change_o pulses once per new PC; done_o=1, pass_o=1, status_o=1 on the next edge; outputs stay frozen for 20 further cycles.
- Register-match and fail: drive PC 0x80000134 with check_value_i=63 -> status_o=2, pass_o=1. Repeat from reset with check_value_i=62 -> status_o=3, pass_o=0.
- Timeout: keep fetching in a loop between 0x80000010 and 0x80000014 -> status_o=4, with done_o rising when cycle_count_o first exceeds 2000. Also drive PC 0x80000130 on that exact cycle -> status_o=1 wins.
- Hang and handshake: hold fetch_rd_i=1 with fetch_accept_i=0 for 256 cycles after RUN -> status_o=5 and fetch_count_o unchanged. A single accept at cycle 255 resets idle_cnt, so no HANG occurs.
- Mid-run reset: assert rst=0 for 1 cycle during RUN with cycle_count_o=500 -> next edge all outputs 0, state IDLE. Re-run the pass path and confirm fetch_count_o restarts from 1.
